// File: rtl/io_buffer_responder_pkg.sv
// Shared defaults, index-width helper and host FSM state type for io_buffer_responder.
package io_buffer_responder_pkg;

  localparam int unsigned IO_DATA_WIDTH_DEF = 256;
  localparam int unsigned IO_ADDR_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF         = 1024;

  // Word-index width for a given depth; a single-word array still needs one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned IDX_WIDTH_DEF = idx_width(DEPTH_DEF);

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  typedef enum logic [0:0] {
    StIdle,
    StRsp
  } host_state_e;

endpackage

// File: rtl/io_buffer_mem.sv
// 1R1W word array with write-first forwarding; rd_word is the forwarded combinational
// lookup and rd_data is its registered copy, loaded only on rd_en.
module io_buffer_mem
  import io_buffer_responder_pkg::*;
#(
  parameter int unsigned DATA_W = IO_DATA_WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_word;
    end
  end

endmodule

// File: rtl/io_buffer_responder.sv
// Responder memory for an IO cell: cell ports always win, host ports use valid/ready.
// Optional counters enabled by defining IO_BUFFER_RESPONDER_STATS_EN.
module io_buffer_responder
  import io_buffer_responder_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH = IO_DATA_WIDTH_DEF,
  parameter int unsigned IO_ADDR_WIDTH = IO_ADDR_WIDTH_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cell_rd_en,
  input  logic [IO_ADDR_WIDTH-1:0] cell_rd_addr,
  output logic [IO_DATA_WIDTH-1:0] cell_rd_data,
  input  logic                     cell_wr_en,
  input  logic [IO_ADDR_WIDTH-1:0] cell_wr_addr,
  input  logic [IO_DATA_WIDTH-1:0] cell_wr_data,
  input  logic                     host_wr_valid,
  output logic                     host_wr_ready,
  input  logic [IO_ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [IO_DATA_WIDTH-1:0] host_wr_data,
  input  logic                     host_rd_valid,
  output logic                     host_rd_ready,
  input  logic [IO_ADDR_WIDTH-1:0] host_rd_addr,
  output logic                     host_rsp_valid,
  input  logic                     host_rsp_ready,
  output logic [IO_DATA_WIDTH-1:0] host_rsp_data
`ifdef IO_BUFFER_RESPONDER_STATS_EN
  ,
  output logic [31:0]              stat_cell_rd,
  output logic [31:0]              stat_cell_wr,
  output logic [31:0]              stat_host_stall
`endif
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  host_state_e             state_q;
  logic                    host_rd_fire;
  logic                    mem_wr_en;
  logic [IDX_W-1:0]        mem_wr_idx;
  logic [IDX_W-1:0]        mem_rd_idx;
  logic [IO_DATA_WIDTH-1:0] mem_wr_data;
  logic [IO_DATA_WIDTH-1:0] mem_rd_word;

  assign host_wr_ready = ~cell_wr_en;
  assign host_rd_ready = ~cell_rd_en & (state_q == StIdle);
  assign host_rd_fire  = host_rd_valid & host_rd_ready;

  // Upper address bits are dropped so addresses wrap modulo DEPTH.
  assign mem_wr_en   = cell_wr_en | host_wr_valid;
  assign mem_wr_idx  = cell_wr_en ? cell_wr_addr[IDX_W-1:0] : host_wr_addr[IDX_W-1:0];
  assign mem_wr_data = cell_wr_en ? cell_wr_data : host_wr_data;
  assign mem_rd_idx  = cell_rd_en ? cell_rd_addr[IDX_W-1:0] : host_rd_addr[IDX_W-1:0];

  if (IO_ADDR_WIDTH > IDX_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{cell_rd_addr[IO_ADDR_WIDTH-1:IDX_W],
                              cell_wr_addr[IO_ADDR_WIDTH-1:IDX_W],
                              host_wr_addr[IO_ADDR_WIDTH-1:IDX_W],
                              host_rd_addr[IO_ADDR_WIDTH-1:IDX_W]};
  end

  io_buffer_mem #(
    .DATA_W (IO_DATA_WIDTH),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_idx  (mem_wr_idx),
    .wr_data (mem_wr_data),
    .rd_en   (cell_rd_en),
    .rd_idx  (mem_rd_idx),
    .rd_word (mem_rd_word),
    .rd_data (cell_rd_data)
  );

  // Host read FSM; the response is held until consumed, so accepts are at most 1 per 2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (host_rd_fire) begin
            host_rsp_data  <= mem_rd_word;
            host_rsp_valid <= 1'b1;
            state_q        <= StRsp;
          end
        end
        StRsp: begin
          if (host_rsp_ready) begin
            host_rsp_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef IO_BUFFER_RESPONDER_STATS_EN
  logic host_stall;

  assign host_stall = (host_wr_valid & ~host_wr_ready) | (host_rd_valid & ~host_rd_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cell_rd    <= '0;
      stat_cell_wr    <= '0;
      stat_host_stall <= '0;
    end else begin
      if (cell_rd_en) stat_cell_rd <= sat_inc(stat_cell_rd);
      if (cell_wr_en) stat_cell_wr <= sat_inc(stat_cell_wr);
      if (host_stall) stat_host_stall <= sat_inc(stat_host_stall);
    end
  end
`endif

endmodule

// File: tb/tb_io_buffer_responder.sv
// Self-checking bench for io_buffer_responder: word-array reference model plus directed cases.
module tb_io_buffer_responder;

  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cell_rd_en = 1'b0;
  logic [AW-1:0] cell_rd_addr = '0;
  logic [DW-1:0] cell_rd_data;
  logic          cell_wr_en = 1'b0;
  logic [AW-1:0] cell_wr_addr = '0;
  logic [DW-1:0] cell_wr_data = '0;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_rd_valid = 1'b0;
  logic          host_rd_ready;
  logic [AW-1:0] host_rd_addr = '0;
  logic          host_rsp_valid;
  logic          host_rsp_ready = 1'b0;
  logic [DW-1:0] host_rsp_data;
`ifdef IO_BUFFER_RESPONDER_STATS_EN
  logic [31:0]   stat_cell_rd;
  logic [31:0]   stat_cell_wr;
  logic [31:0]   stat_host_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  io_buffer_responder #(
    .IO_DATA_WIDTH (DW),
    .IO_ADDR_WIDTH (AW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cell_rd_en     (cell_rd_en),
    .cell_rd_addr   (cell_rd_addr),
    .cell_rd_data   (cell_rd_data),
    .cell_wr_en     (cell_wr_en),
    .cell_wr_addr   (cell_wr_addr),
    .cell_wr_data   (cell_wr_data),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_rd_valid  (host_rd_valid),
    .host_rd_ready  (host_rd_ready),
    .host_rd_addr   (host_rd_addr),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_data  (host_rsp_data)
`ifdef IO_BUFFER_RESPONDER_STATS_EN
    ,
    .stat_cell_rd    (stat_cell_rd),
    .stat_cell_wr    (stat_cell_wr),
    .stat_host_stall (stat_host_stall)
`endif
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain word array; the cell wins each port, writes land before reads.
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] m_cell_rd = '0;
  logic          m_rsp_valid = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic [31:0]   m_st_rd = '0;
  logic [31:0]   m_st_wr = '0;
  logic [31:0]   m_st_stall = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cell_rd   = '0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        m_st_rd     = '0;
        m_st_wr     = '0;
        m_st_stall  = '0;
      end else begin
        if (cell_rd_en) m_st_rd++;
        if (cell_wr_en) m_st_wr++;
        if ((host_wr_valid && cell_wr_en) || (host_rd_valid && (cell_rd_en || m_rsp_valid)))
          m_st_stall++;
        if (cell_wr_en) mdl_mem[cell_wr_addr % DEPTH] = cell_wr_data;
        else if (host_wr_valid) mdl_mem[host_wr_addr % DEPTH] = host_wr_data;
        if (cell_rd_en) m_cell_rd = mdl_mem[cell_rd_addr % DEPTH];
        if (m_rsp_valid) begin
          if (host_rsp_ready) m_rsp_valid = 1'b0;
        end else if (host_rd_valid && !cell_rd_en) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = mdl_mem[host_rd_addr % DEPTH];
        end
      end
    end
  end

  // Every-cycle comparison, inside the low clock phase after inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("cell_rd_data", cell_rd_data, m_cell_rd);
      chk("host_rsp_valid", host_rsp_valid, m_rsp_valid);
      if (m_rsp_valid) chk("host_rsp_data", host_rsp_data, m_rsp_data);
      chk("host_wr_ready", host_wr_ready, !cell_wr_en);
      chk("host_rd_ready", host_rd_ready, !cell_rd_en && !m_rsp_valid);
`ifdef IO_BUFFER_RESPONDER_STATS_EN
      chk("stat_cell_rd", stat_cell_rd, m_st_rd);
      chk("stat_cell_wr", stat_cell_wr, m_st_wr);
      chk("stat_host_stall", stat_host_stall, m_st_stall);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    cell_rd_en     = 1'b0;
    cell_wr_en     = 1'b0;
    host_wr_valid  = 1'b0;
    host_rd_valid  = 1'b0;
    host_rsp_ready = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Mix of a few hot words (with wrapping aliases) and fully random addresses.
  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 3) + DEPTH * $urandom_range(0, 63));
    else a = AW'($urandom);
    return a;
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    #1;
    chk("reset cell_rd_data", cell_rd_data, '0);
    chk("reset host_rsp_valid", host_rsp_valid, '0);
    chk("reset host_rsp_data", host_rsp_data, '0);
    tick();
    rst = 1'b0;

    // Preload every word through the host port
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      idle();
      host_wr_valid = 1'b1;
      host_wr_addr  = AW'(i);
      host_wr_data  = rand_word();
    end

    // Host write then cell read: data one cycle after the read request
    tick(); idle();
    host_wr_valid = 1'b1; host_wr_addr = 16'd3; host_wr_data = 256'hA5;
    tick(); idle();
    cell_rd_en = 1'b1; cell_rd_addr = 16'd3;
    tick(); idle();
    #1 chk("host wr / cell rd addr3", cell_rd_data, 256'hA5);

    // Same-cycle cell write and read of one word is write-first
    tick(); idle();
    cell_wr_en = 1'b1; cell_wr_addr = 16'd7; cell_wr_data = 256'h11;
    cell_rd_en = 1'b1; cell_rd_addr = 16'd7;
    tick(); idle();
    #1 chk("write-first addr7", cell_rd_data, 256'h11);

    // Host write stalled by three cell writes, commits on the fourth cycle
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      host_wr_valid = 1'b1; host_wr_addr = 16'd9; host_wr_data = 256'h77;
      cell_wr_en = 1'b1; cell_wr_addr = 16'd20; cell_wr_data = 256'h2000 + 256'(c);
      #1 chk("host_wr_ready low under cell write", host_wr_ready, 1'b0);
    end
    tick(); idle();
    host_wr_valid = 1'b1; host_wr_addr = 16'd9; host_wr_data = 256'h77;
    #1 chk("host_wr_ready after cell write", host_wr_ready, 1'b1);
    tick(); idle();
    cell_rd_en = 1'b1; cell_rd_addr = 16'd9;
    tick(); idle();
    #1 chk("stalled host write readback", cell_rd_data, 256'h77);

    // Host read response held while host_rsp_ready is low
    tick(); idle();
    host_wr_valid = 1'b1; host_wr_addr = 16'd5; host_wr_data = 256'h42;
    tick(); idle();
    host_rd_valid = 1'b1; host_rd_addr = 16'd5;
    #1 chk("host_rd_ready idle", host_rd_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      chk("held host_rsp_valid", host_rsp_valid, 1'b1);
      chk("held host_rsp_data", host_rsp_data, 256'h42);
      chk("host_rd_ready in RSP", host_rd_ready, 1'b0);
    end
    host_rd_valid = 1'b0; host_rsp_ready = 1'b1;
    tick(); idle();
    #1 chk("host_rsp_valid cleared", host_rsp_valid, 1'b0);

    // Address wrap: DEPTH+2 aliases word 2
    tick(); idle();
    cell_wr_en = 1'b1; cell_wr_addr = 16'(DEPTH + 2); cell_wr_data = 256'h99;
    tick(); idle();
    host_rd_valid = 1'b1; host_rd_addr = 16'd2;
    tick(); idle();
    #1 chk("wrap host_rsp_data", host_rsp_data, 256'h99);
    host_rsp_ready = 1'b1;
    tick(); idle();

    // Asynchronous reset while a response is pending
    cell_rd_en = 1'b1; cell_rd_addr = 16'd7;
    tick(); idle();
    host_rd_valid = 1'b1; host_rd_addr = 16'd5;
    tick(); idle();
    #1;
    chk("pre-reset host_rsp_valid", host_rsp_valid, 1'b1);
    chk("pre-reset cell_rd_data", cell_rd_data, 256'h11);
    #2 rst = 1'b1;
    #1;
    chk("async rst host_rsp_valid", host_rsp_valid, 1'b0);
    chk("async rst host_rsp_data", host_rsp_data, '0);
    chk("async rst cell_rd_data", cell_rd_data, '0);
`ifdef IO_BUFFER_RESPONDER_STATS_EN
    chk("async rst stat_cell_rd", stat_cell_rd, '0);
    chk("async rst stat_cell_wr", stat_cell_wr, '0);
    chk("async rst stat_host_stall", stat_host_stall, '0);
`endif
    tick();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      cell_rd_en     = ($urandom_range(0, 99) < 40);
      cell_rd_addr   = rand_addr();
      cell_wr_en     = ($urandom_range(0, 99) < 40);
      cell_wr_addr   = rand_addr();
      cell_wr_data   = rand_word();
      host_wr_valid  = ($urandom_range(0, 99) < 50);
      host_wr_addr   = rand_addr();
      host_wr_data   = rand_word();
      host_rd_valid  = ($urandom_range(0, 99) < 50);
      host_rd_addr   = rand_addr();
      host_rsp_ready = ($urandom_range(0, 99) < 60);
    end
    tick(); idle();
    tick();
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_buffer_responder.md
Name: io_buffer_responder

Overview:
Responder-side memory that serves the IO read/write request ports driven by an input/output cell. It returns read data with fixed 1-cycle latency and absorbs write requests; the cell side has no backpressure. A secondary host port with valid/ready handshakes lets the testbench or system DMA preload input vectors and drain results. The cell side always has priority over the host.

Parameters:
IO_DATA_WIDTH, 256, word width; must equal the cell's IO data width.
IO_ADDR_WIDTH, 16, address width on all ports.
DEPTH, 1024, number of words; must be a power of two and at most 2**IO_ADDR_WIDTH.

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-high
cell_rd_en  input  1  cell read request (from cell io_en_in)
cell_rd_addr  input  IO_ADDR_WIDTH  cell read address
cell_rd_data  output  IO_DATA_WIDTH  read data, valid the cycle after cell_rd_en
cell_wr_en  input  1  cell write request (from cell io_en_out)
cell_wr_addr  input  IO_ADDR_WIDTH  cell write address
cell_wr_data  input  IO_DATA_WIDTH  cell write data
host_wr_valid  input  1  host write request
host_wr_ready  output  1  host write accepted this cycle when high with valid
host_wr_addr  input  IO_ADDR_WIDTH  host write address
host_wr_data  input  IO_DATA_WIDTH  host write data
host_rd_valid  input  1  host read request
host_rd_ready  output  1  host read request accepted
host_rd_addr  input  IO_ADDR_WIDTH  host read address
host_rsp_valid  output  1  host read response valid
host_rsp_ready  input  1  host consumes response
host_rsp_data  output  IO_DATA_WIDTH  host read response data

Behaviour:
- Storage: DEPTH x IO_DATA_WIDTH array with 1 read and 1 write per cycle. Only the low log2(DEPTH) address bits are used; upper bits are ignored, so addresses wrap.
- Reset (rst high, asynchronous): cell_rd_data=0, host_rsp_valid=0, host_rsp_data=0, host FSM goes to IDLE. Array contents are not reset. Reset asserted mid-transaction drops any pending host response.
- Write port arbitration: cell_wr_en wins. host_wr_ready = ~cell_wr_en (combinational). A host write commits at the clock edge where host_wr_valid & host_wr_ready.
- Read port arbitration: cell_rd_en wins. host_rd_ready = ~cell_rd_en & (state==IDLE).
- Cell read: cell_rd_data is registered and updates at the edge after cell_rd_en. It holds its value when there is no read.
- Read-during-write to the same word in the same cycle is write-first. Read data returns the new write data, whichever port supplied the write.
- Host read FSM:
  - IDLE: on host_rd_valid & host_rd_ready, capture data (write-first applies) into host_rsp_data, set host_rsp_valid=1, go to RSP.
  - RSP: host_rsp_data and host_rsp_valid are held stable until host_rsp_ready. On host_rsp_ready, clear valid and return to IDLE. No back-to-back accept in the same cycle, so maximum host read throughput is 1 per 2 cycles.
- A cell read and a cell write in the same cycle to different addresses are both served.
- The cell never stalls. Host starvation under continuous cell traffic is allowed by design.

Optional Feature:
Macro: IO_BUFFER_RESPONDER_STATS_EN.
- Defined: adds three 32-bit saturating counters, exposed as outputs stat_cell_rd, stat_cell_wr and stat_host_stall.
  - stat_cell_rd and stat_cell_wr count cell_rd_en and cell_wr_en cycles.
  - stat_host_stall counts cycles with (host_wr_valid & ~host_wr_ready) | (host_rd_valid & ~host_rd_ready).
  - Counters reset to 0 and stick at 0xFFFFFFFF.
- Undefined: counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Package io_buffer_responder_pkg holds the default widths/depth, a derived constant for the index width (log2 DEPTH), and the host FSM state enum (IDLE, RSP).
- One natural sub-module, io_buffer_mem: the 1R1W array with write-first forwarding and a registered read output.

Test Plan:
- Host writes 0xA5 (zero-extended) to addr 3, then cell_rd_en with addr 3 -> cell_rd_data=0xA5 exactly one cycle later.
- Cell writes 0x11 to addr 7 while cell reads addr 7 in the same cycle -> cell_rd_data=0x11 next cycle (write-first).
- host_wr_valid held with cell_wr_en high for 3 cycles -> host_wr_ready=0 for those 3 cycles. The host write commits on cycle 4 and readback matches.
- Host read of addr 5 (holding 0x42) with host_rsp_ready low for 4 cycles -> host_rsp_valid and data 0x42 stay stable and host_rd_ready=0 throughout. Raising ready clears valid on the next edge.
- Cell write to addr DEPTH+2 with data 0x99, then host read of addr 2 -> response 0x99 (address wrap).
- Assert rst while host_rsp_valid=1 -> host_rsp_valid and cell_rd_data go to 0 immediately, without waiting for a clock edge. With the stats macro defined, all counters read 0.
